// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [10:0]      id_ctrl,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [9:0]       id_funct,
   input  logic             ex_flush,
   input  logic             hold,
   output logic [10:0]      ex_ctrl,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [9:0]       ex_funct,
   output logic             ex_valid,
   output logic             stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   // bit 7 of the control word is MemRead
   localparam int MEMREAD_BIT = 7;

   logic lu;

   // load in EX whose destination is read by the instruction in ID; rs1/rs2 are
   // not qualified by opcode, so LUI/JAL/AUIPC may stall spuriously (harmless)
   always_comb begin
      lu    = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rd != 5'd0) &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));
      stall = lu & ~ex_flush;
   end

   // pipeline register: reset > flush > hold > load-use bubble > capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
         ex_valid    <= 1'b0;
      end else if (ex_flush || (!hold && lu)) begin
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
         ex_valid    <= 1'b0;
      end else if (!hold) begin
         // an invalid slot carries no control so it can never write state
         ex_ctrl     <= id_valid ? id_ctrl : 11'd0;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct    <= id_funct;
         ex_valid    <= id_valid;
      end
   end

   // saturating count of load-use bubbles; flush and hold never count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (!ex_flush && !hold && lu && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the five-stage RISC-V core; sits directly downstream of the main decode controller.
- Latches the 11-bit control word and the ID-stage datapath fields into the EX stage.
- Contains the load-use hazard detector; inserts a zero-control bubble and raises a stall toward the PC and IF/ID.
- Honours the branch/jump flush from EX and a global pipeline hold; keeps a saturating count of load-use bubbles.

Parameters:
XLEN, 32, datapath word width
CNT_W, 16, width of the bubble performance counter

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  synchronous reset, active-low
id_valid  in  1  ID stage holds a real instruction
id_ctrl  in  11  {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalrSel, RWSel[1:0]}; bit 10 = ALUSrc, bit 7 = MemRead
id_pc  in  XLEN  PC of the ID instruction
id_rs1_data  in  XLEN  register file read data 1
id_rs2_data  in  XLEN  register file read data 2
id_imm  in  XLEN  immediate-generator output
id_rs1  in  5  source register index 1
id_rs2  in  5  source register index 2
id_rd  in  5  destination register index
id_funct  in  10  {funct7, funct3}
ex_flush  in  1  branch/jump taken in EX; kill the ID instruction
hold  in  1  global freeze, e.g. memory wait
ex_ctrl  out  11  registered control word
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered datapath fields
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
ex_funct  out  10  registered funct field
ex_valid  out  1  EX holds a real instruction
stall  out  1  combinational; freeze PC and IF/ID this cycle
bubble_cnt  out  CNT_W  count of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0 at a rising edge): every ex_* output, ex_valid and bubble_cnt go to 0. Reset takes priority over every other input.
- Load-use condition `lu` (combinational):
  - Requires ex_valid & ex_ctrl[7] & id_valid & (ex_rd != 0).
  - Also requires (ex_rd == id_rs1 | ex_rd == id_rs2).
  - No opcode qualification of rs1/rs2. Spurious stalls for LUI/JAL/AUIPC are accepted (performance cost only).
- stall = lu & ~ex_flush. Combinational; independent of hold.
- Register update priority per rising edge when rst_n=1:
  1. ex_flush=1: load a bubble. All ex_* = 0, ex_valid = 0. Overrides hold and lu.
  2. hold=1: all registers keep their value, including ex_valid.
  3. lu=1: load a bubble (all ex_* = 0, ex_valid = 0) and increment bubble_cnt.
  4. Otherwise: capture all id_* inputs.
     - ex_valid = id_valid.
     - If id_valid=0, ex_ctrl = 0 so an invalid slot never writes registers or memory.
- bubble_cnt:
  - Increments only in case 3.
  - Saturates at 2^CNT_W − 1 with no wrap.
  - Unaffected by flush and hold; cleared only by reset.
- Latency: one cycle from id_* to ex_*. There is no combinational path from id_* to ex_*.
- A stalled instruction stays in ID. After the bubble, the load's ex_rd no longer matches, so the instruction advances on the next edge. Exactly one bubble is inserted per load-use pair.
- Back-to-back loads into the same rd: each dependent consumer gets its own single bubble.
- ex_flush and lu in the same cycle: bubble is inserted, stall=0, bubble_cnt unchanged.
- Reset asserted mid-stall: all state clears. stall falls on the following cycle because ex_valid=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random id_* → all ex_*, ex_valid, bubble_cnt = 0.
- Normal capture: id_ctrl=11'b00100100000, id_pc=0x100, id_rd=5, id_valid=1 → next cycle ex_ctrl=11'b00100100000, ex_pc=0x100, ex_rd=5, ex_valid=1, stall=0.
- Load-use: EX holds a load (ex_ctrl=11'b11110000000, ex_rd=7); ID has id_rs2=7 →
  - stall=1; next edge ex_ctrl=0, ex_valid=0, bubble_cnt=1.
  - Following cycle stall=0 and the ID instruction is captured.
  - Repeat with ex_rd=0 → no stall.
- Flush priority: lu=1 and ex_flush=1 together → stall=0; next edge ex_valid=0, bubble_cnt unchanged. Repeat with hold=1 → still a bubble.
- Hold: hold=1 for 3 cycles while id_* changes → ex_* unchanged; stall still tracks lu.
- Saturation: CNT_W=2, force 5 load-use events → bubble_cnt reads 1,2,3,3,3.
